// File: rtl/pio_gen.sv
`default_nettype none
// ============================================================================
// Module      : pio_gen
// Description : Avalon-MM slave parallel I/O. WIDTH-bit output register with
//               atomic set/clear aliases, plus a WIDTH-bit input port with a
//               synchroniser, per-bit edge capture and a maskable, registered
//               level interrupt.
// Ports       : clk, reset           - single clock, async active-high reset
//               address/chipselect/
//               write_n/read_n/
//               writedata/readdata   - Avalon-MM slave, 1-cycle read latency
//               in_port              - asynchronous external inputs
//               out_port             - output register
//               irq                  - level interrupt to the CPU
// Revision    : 1.0 - initial release
// ============================================================================
module pio_gen #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] c_addr_data     = 3'd0;
    localparam logic [2:0] c_addr_output   = 3'd1;
    localparam logic [2:0] c_addr_irq_mask = 3'd2;
    localparam logic [2:0] c_addr_edge_cap = 3'd3;
    localparam logic [2:0] c_addr_outset   = 3'd4;
    localparam logic [2:0] c_addr_outclr   = 3'd5;

    logic                                w_wr;
    logic                                w_rd;
    logic [WIDTH-1:0]                    w_wd;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;
    logic [WIDTH-1:0]                    w_sync_in;
    logic [WIDTH-1:0]                    r_prev;
    logic [WIDTH-1:0]                    w_edge;
    logic [WIDTH-1:0]                    r_edge_cap;
    logic [WIDTH-1:0]                    r_irq_mask;
    logic [WIDTH-1:0]                    w_cap_clr;
    logic [31:0]                         w_rd_mux;
    logic                                w_unused_wd;

    assign w_wr      = chipselect & ~write_n;
    assign w_rd      = chipselect & ~read_n;
    assign w_wd      = writedata[WIDTH-1:0];
    // Only the low WIDTH bits of writedata carry meaning.
    assign w_unused_wd = ^writedata;

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 samples the pin, the last stage is the
    // value the rest of the block treats as the input.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_sync_in;
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge = w_sync_in & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~w_sync_in & r_prev;
        end else begin : g_edge_any
            assign w_edge = w_sync_in ^ r_prev;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register with direct load and atomic set/clear aliases.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= RESET_VALUE;
        end else if (w_wr) begin
            case (address)
                c_addr_data,
                c_addr_output: out_port <= w_wd;
                c_addr_outset: out_port <= out_port | w_wd;
                c_addr_outclr: out_port <= out_port & ~w_wd;
                default:       out_port <= out_port;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Interrupt mask, edge capture and interrupt.
    // The clear is applied before OR-ing in new edges so a fresh edge in
    // the same cycle as a write-1-to-clear keeps the bit set.
    // ------------------------------------------------------------------
    assign w_cap_clr = (w_wr && (address == c_addr_edge_cap)) ? w_wd : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            irq        <= 1'b0;
        end else begin
            if (w_wr && (address == c_addr_irq_mask)) begin
                r_irq_mask <= w_wd;
            end
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
            // Built from the registered state, so irq trails capture/mask
            // changes by exactly one cycle.
            irq        <= |(r_edge_cap & r_irq_mask);
        end
    end

    // ------------------------------------------------------------------
    // Read path: sampled from pre-write register values, zero-extended.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_addr_data:     w_rd_mux[WIDTH-1:0] = w_sync_in;
            c_addr_output:   w_rd_mux[WIDTH-1:0] = out_port;
            c_addr_irq_mask: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            c_addr_edge_cap: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:         w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (w_rd) begin
            readdata <= w_rd_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_gen
// Description : Directed self-checking bench for pio_gen. Three instances:
//               A (8 bit, rising, 2 stages, reset 0x3C), B (8 bit, any edge,
//               3 stages), C (4 bit, falling, 2 stages, reset 0x5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_gen;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic        cs_a, cs_b, cs_c;
    logic [7:0]  in_a, in_b, out_a, out_b;
    logic [3:0]  in_c, out_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] d;

    pio_gen #(.WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .in_port(in_a), .out_port(out_a), .readdata(rd_a), .irq(irq_a));

    pio_gen #(.WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .in_port(in_b), .out_port(out_b), .readdata(rd_b), .irq(irq_b));

    pio_gen #(.WIDTH(4), .RESET_VALUE(4'h5), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_c),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .in_port(in_c), .out_port(out_c), .readdata(rd_c), .irq(irq_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus tasks are entered on a negedge and return on the next negedge.
    task automatic bus_write(input int sel, input logic [2:0] a, input logic [31:0] wd);
        cs_a = (sel == 0); cs_b = (sel == 1); cs_c = (sel == 2);
        address = a; writedata = wd; write_n = 1'b0;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input int sel, input logic [2:0] a, output logic [31:0] rdv);
        cs_a = (sel == 0); cs_b = (sel == 1); cs_c = (sel == 2);
        address = a; read_n = 1'b0;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0; read_n = 1'b1;
        rdv = (sel == 0) ? rd_a : (sel == 1) ? rd_b : rd_c;
    endtask

    task automatic test_reset;
        checks++; if (out_a !== 8'h3C) begin errors++; $display("FAIL reset_out_a: got %h want 3c", out_a); end
        checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out_b: got %h want 00", out_b); end
        checks++; if (out_c !== 4'h5) begin errors++; $display("FAIL reset_out_c: got %h want 5", out_c); end
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL reset_irq_a: got %b want 0", irq_a); end
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_readdata_a: got %h want 0", rd_a); end
    endtask

    task automatic test_set_clear;
        bus_write(0, 3'd0, 32'hA5);
        checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL data_write: got %h want a5", out_a); end
        bus_write(0, 3'd4, 32'h0F);
        checks++; if (out_a !== 8'hAF) begin errors++; $display("FAIL outset: got %h want af", out_a); end
        bus_write(0, 3'd5, 32'h81);
        checks++; if (out_a !== 8'h2E) begin errors++; $display("FAIL outclr: got %h want 2e", out_a); end
        bus_read(0, 3'd1, d);
        checks++; if (d !== 32'h2E) begin errors++; $display("FAIL read_output: got %h want 2e", d); end
        bus_read(0, 3'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_outset: got %h want 0", d); end
        bus_read(0, 3'd5, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_outclr: got %h want 0", d); end
    endtask

    task automatic test_rising_irq;
        bus_write(0, 3'd2, 32'h01);
        in_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq_a); end
        @(negedge clk);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_latency: got %b want 1", irq_a); end
        bus_read(0, 3'd3, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL edge_cap_rise: got %h want 01", d); end
        bus_read(0, 3'd0, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL read_data: got %h want 01", d); end
    endtask

    task automatic test_w1c_race;
        in_a[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL fall_ignored_irq: got %b want 1", irq_a); end
        in_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        // The clear lands on the same edge that captures the new rising edge.
        bus_write(0, 3'd3, 32'h01);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL race_irq: got %b want 1", irq_a); end
        bus_read(0, 3'd3, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL race_cap: got %h want 01", d); end
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL race_irq_hold: got %b want 1", irq_a); end
        bus_write(0, 3'd3, 32'h01);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL clear_irq_lag: got %b want 1", irq_a); end
        @(negedge clk);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL clear_irq_drop: got %b want 0", irq_a); end
        bus_read(0, 3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_cap: got %h want 0", d); end
    endtask

    task automatic test_any_edge_mask;
        in_b[3] = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(1, 3'd3, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL any_rise_cap: got %h want 08", d); end
        checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b want 0", irq_b); end
        bus_write(1, 3'd2, 32'h08);
        checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL unmask_lag: got %b want 0", irq_b); end
        @(negedge clk);
        checks++; if (irq_b !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b want 1", irq_b); end
        bus_write(1, 3'd3, 32'h08);
        in_b[3] = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL sync3_early: got %b want 0", irq_b); end
        @(negedge clk);
        checks++; if (irq_b !== 1'b1) begin errors++; $display("FAIL sync3_latency: got %b want 1", irq_b); end
        bus_read(1, 3'd3, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL any_fall_cap: got %h want 08", d); end
    endtask

    task automatic test_reserved_width;
        bus_read(0, 3'd6, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_addr6: got %h want 0", d); end
        bus_read(0, 3'd7, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_addr7: got %h want 0", d); end
        bus_write(0, 3'd6, 32'hFF);
        bus_read(0, 3'd1, d);
        checks++; if (d !== 32'h2E) begin errors++; $display("FAIL write_addr6_ignored: got %h want 2e", d); end
        bus_write(2, 3'd0, 32'hFFFF_FFFF);
        checks++; if (out_c !== 4'hF) begin errors++; $display("FAIL width4_out: got %h want f", out_c); end
        bus_read(2, 3'd1, d);
        checks++; if (d !== 32'h0000_000F) begin errors++; $display("FAIL width4_read: got %h want 0000000f", d); end
    endtask

    task automatic test_falling;
        bus_write(2, 3'd2, 32'h1);
        in_c[0] = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (irq_c !== 1'b0) begin errors++; $display("FAIL fall_rise_irq: got %b want 0", irq_c); end
        bus_read(2, 3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL fall_rise_cap: got %h want 0", d); end
        in_c[0] = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (irq_c !== 1'b1) begin errors++; $display("FAIL fall_irq: got %b want 1", irq_c); end
        bus_read(2, 3'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL fall_cap: got %h want 1", d); end
    endtask

    task automatic test_same_cycle_rw;
        cs_a = 1'b1; address = 3'd1; writedata = 32'h55; write_n = 1'b0; read_n = 1'b0;
        @(negedge clk);
        cs_a = 1'b0; write_n = 1'b1; read_n = 1'b1;
        checks++; if (rd_a !== 32'h2E) begin errors++; $display("FAIL rw_prewrite: got %h want 2e", rd_a); end
        checks++; if (out_a !== 8'h55) begin errors++; $display("FAIL rw_write: got %h want 55", out_a); end
        // Strobes without chipselect must do nothing.
        address = 3'd1; writedata = 32'h0; write_n = 1'b0; read_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1; read_n = 1'b1;
        checks++; if (out_a !== 8'h55) begin errors++; $display("FAIL cs0_write: got %h want 55", out_a); end
        checks++; if (rd_a !== 32'h2E) begin errors++; $display("FAIL cs0_read_hold: got %h want 2e", rd_a); end
    endtask

    task automatic test_reset_midrun;
        bus_write(0, 3'd1, 32'hFF);
        bus_write(0, 3'd2, 32'hFF);
        in_a = 8'h03;
        repeat (5) @(negedge clk);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq_a); end
        bus_read(0, 3'd1, d);
        checks++; if (d !== 32'hFF) begin errors++; $display("FAIL pre_reset_out: got %h want ff", d); end
        in_a = 8'h00;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_a !== 8'h3C) begin errors++; $display("FAIL midrun_out_a: got %h want 3c", out_a); end
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL midrun_irq: got %b want 0", irq_a); end
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL midrun_readdata: got %h want 0", rd_a); end
        checks++; if (out_c !== 4'h5) begin errors++; $display("FAIL midrun_out_c: got %h want 5", out_c); end
        @(negedge clk);
        reset = 1'b0;
        bus_read(0, 3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_cap: got %h want 0", d); end
        bus_read(0, 3'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_mask: got %h want 0", d); end
        repeat (4) @(negedge clk);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b want 0", irq_a); end
    endtask

    initial begin
        reset = 1'b1;
        address = 3'd0; writedata = 32'h0; write_n = 1'b1; read_n = 1'b1;
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
        in_a = 8'h00; in_b = 8'h00; in_c = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_set_clear();
        test_rising_irq();
        test_w1c_race();
        test_any_edge_mask();
        test_reserved_width();
        test_falling();
        test_same_cycle_rw();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
